// File: rtl/teclado_pkg.sv
// Shared types, constants and helpers for the decimal keypad input stage.
package teclado_pkg;

    localparam int N_KEYS               = 10;
    localparam int DEBOUNCE_CYCLES_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // True when exactly one key line is active.
    function automatic logic is_onehot(input logic [9:0] x);
        return (x != 10'd0) && ((x & (x - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/teclado_decimal_debounce_if.sv
// Keypad-side bus: raw key lines in, debounced one-hot code and status out.
interface teclado_decimal_debounce_if;
    import teclado_pkg::*;

    logic [N_KEYS-1:0] keys;
    logic [N_KEYS-1:0] D;
    logic              key_valid;
    logic              key_held;
    logic              multi_err;

    modport master (
        output keys,
        input  D, key_valid, key_held, multi_err
    );

    modport slave (
        input  keys,
        output D, key_valid, key_held, multi_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bank for asynchronous inputs, async active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/teclado_decimal_debounce.sv
// Debounces a 10-key decimal keypad, rejects simultaneous presses and latches
// each accepted key as a one-hot code with a single-cycle strobe.
module teclado_decimal_debounce
    import teclado_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    teclado_decimal_debounce_if.slave   bus
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [N_KEYS-1:0] w_sync;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_KEYS-1:0] r_cand;
    logic [N_KEYS-1:0] r_d;
    logic              r_valid;
    logic              r_held;
    logic              r_multi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
    endfunction

    sync_2ff #(.WIDTH(N_KEYS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.keys),
        .o_q   (w_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (is_onehot(w_sync)) begin
                        r_cand <= w_sync;
                        // A single stable sample is already enough when DEBOUNCE_CYCLES is 1.
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_d     <= w_sync;
                            r_valid <= 1'b1;
                            r_held  <= 1'b1;
                            r_multi <= 1'b0;
                            r_state <= HELD;
                        end else begin
                            r_cnt   <= CNT_ONE;
                            r_state <= DB_PRESS;
                        end
                    end else if (w_sync != '0) begin
                        r_multi <= 1'b1;
                    end else begin
                        r_multi <= 1'b0;
                    end
                end
                DB_PRESS: begin
                    if (w_sync != r_cand) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_multi <= (w_sync != '0) && !is_onehot(w_sync);
                    end else if (r_cnt >= CNT_LAST) begin
                        r_d     <= r_cand;
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
                        r_multi <= 1'b0;
                        r_state <= HELD;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                HELD: begin
                    // Extra or changed keys while held are deliberately ignored.
                    if (w_sync == '0) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_held  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= CNT_ONE;
                            r_state <= DB_RELEASE;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (w_sync != '0) begin
                        r_state <= HELD;
                    end else if (r_cnt >= CNT_LAST) begin
                        r_held  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.D         = r_d;
    assign bus.key_valid = r_valid;
    assign bus.key_held  = r_held;
    assign bus.multi_err = r_multi;

endmodule

// File: doc/teclado_decimal_debounce.md
Name: teclado_decimal_debounce

Overview:
Input stage for a 10-key decimal keypad (keys 0..9). It synchronises and debounces the raw key lines and rejects simultaneous presses. It latches each accepted key as a clean 1-of-10 code on D[9:0], which feeds the decimal-to-BCD encoder directly, and emits a one-cycle strobe per accepted press.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a press or a release; must be >= 1 (use 4 in simulation, about 50000 at 50 MHz in hardware).
N_KEYS, 10, number of key lines; fixed at 10 for the decimal encoder.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
keys  input  N_KEYS  raw asynchronous key lines, 1 = pressed, bounce expected.
D  output  N_KEYS  last accepted key, one-hot; drives the encoder input D.
key_valid  output  1  one-cycle pulse when a new key is accepted.
key_held  output  1  high while the accepted key is still considered pressed.
multi_err  output  1  high while two or more keys are pressed with no key accepted.

Behaviour:
- Reset (reset=0, asynchronous): synchroniser flops=0, state=IDLE, counter=0, candidate=0, D=0, key_valid=0, key_held=0, multi_err=0.
- Synchroniser: 2-flop chain per line; sync_keys lags keys by 2 edges. The FSM sees only sync_keys.
- onehot(x): exactly one bit of x is set.
- IDLE:
  - If onehot(sync_keys): candidate<=sync_keys, count<=1, go to DB_PRESS (or accept immediately if DEBOUNCE_CYCLES=1).
  - If popcount >= 2: multi_err<=1, stay in IDLE.
  - If sync_keys=0: multi_err<=0, stay in IDLE.
- DB_PRESS:
  - If sync_keys != candidate: abort to IDLE, count<=0. multi_err<=1 if popcount >= 2, else 0.
  - Otherwise count<=count+1. At the edge where count reaches DEBOUNCE_CYCLES: D<=candidate, key_valid<=1, multi_err<=0, go to HELD.
- HELD: key_held=1. Extra or changed keys are ignored (no new strobe, D unchanged). When sync_keys=0: count<=1, go to DB_RELEASE.
- DB_RELEASE: key_held=1.
  - Any nonzero sync_keys: back to HELD.
  - DEBOUNCE_CYCLES consecutive zero samples: go to IDLE, key_held<=0.
- key_valid is high for exactly one cycle per accepted press. It is never high in two consecutive cycles.
- D holds the last accepted key indefinitely, including across releases. It is 0 only after reset.
- Latency: with keys stable before edge 0, key_valid and D update after edge DEBOUNCE_CYCLES+1, i.e. they are visible DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). It saturates; it never wraps.
- Reset mid-debounce or mid-hold: everything returns to reset values immediately, with no strobe. After reset is released, a key still held is re-debounced from IDLE as a fresh press.
- All outputs are registered; no combinational path from keys to any output.

Decomposition:
- Package teclado_pkg: state encoding localparams (IDLE, DB_PRESS, HELD, DB_RELEASE, 2 bits), DEBOUNCE_CYCLES default, N_KEYS=10, and a function is_onehot(input [9:0]).
- Sub-module sync_2ff: parameterised width, async active-low reset, instantiated once for all N_KEYS lines.
- FSM, counter and output registers live in teclado_decimal_debounce.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset low for 1 cycle. keys=10'b0000001000 held 10 cycles -> key_valid pulses once, 6 cycles after application. D=10'b0000001000, key_held=1, multi_err=0; encoder chained downstream gives BCD=0011.
- Sweep i=0..9: press keys=1<<i for 8 cycles, release for 8 cycles -> exactly one key_valid per key, D=1<<i, downstream BCD=i, key_held returns to 0 after release debounce.
- Glitch: key 5 high for 2 cycles, then 0 -> no key_valid, D unchanged, state back to IDLE.
- Bounce: key 7 toggling 1,0,1,0 each cycle, then stable 1 -> exactly one key_valid, 6 cycles after stable start, D=10'b0010000000. Release bounce 0,1,0 then stable 0 -> no second strobe, key_held drops after 4 stable zeros.
- Multi-key: keys=10'b0010001000 (3 and 7) for 10 cycles -> multi_err=1 from 3 cycles after application, no key_valid, D keeps its previous value. Release to only key 3 -> multi_err=0, key 3 accepted.
- Reset mid-operation: assert reset=0 during DB_PRESS of key 9 -> no key_valid, D=0. Release reset with key 9 still held -> key 9 accepted 6 cycles later.
